rep_code_tx: RTL
================

Name: rep_code_tx

Overview:
- Repetition-code transmitter: the sending end of the team's majority-vote receive path.
- Accepts parallel words over a valid/ready handshake and emits each as a serial chip stream, one chip per clock.
- Each bit (a start bit, then data MSB first) is repeated REP times so the downstream voter can recover it by majority.
- Sits between the word-level datapath and the serial link driver.

Parameters:
DATA_W  8  data word width in bits (>=1)
REP     4  chips per bit (>=2); 4 pairs with the 3-of-4 majority receiver

Ports:
clk      in   1       single clock, rising edge
rst      in   1       asynchronous, active-high reset
in_data  in   DATA_W  word to send
in_valid in   1       in_data valid
in_ready out  1       block can accept a word this cycle
tx_hold  in   1       link stall: freeze current chip
tx_bit   out  1       current chip value
tx_en    out  1       tx_bit is a live chip of a frame
tx_last  out  1       current chip is the final chip of the frame
busy     out  1       frame in progress (equals tx_en)

Behaviour:
- Reset (rst=1, asynchronous): tx_bit=0, tx_en=0, tx_last=0, busy=0, counters cleared, state=IDLE.
  - Any frame in flight is aborted and its word discarded.
  - in_ready is 0 while rst is asserted and is 1 in the first cycle after release.
- Frame layout, total (1+DATA_W)*REP chips:
  - START bit (value 1) for REP chips.
  - Then in_data[DATA_W-1] down to in_data[0], each for REP chips.
- Handshake:
  - A word is accepted on a rising edge where in_valid && in_ready.
  - The word is captured into a shift register at that edge; in_data may change afterwards.
- in_ready = (state==IDLE) || (state==SEND && tx_last && !tx_hold). It is combinational from state only and never depends on in_valid.
- Latency: the first START chip appears on tx_bit with tx_en=1 in the cycle after acceptance.
- Back-to-back: acceptance on the last chip of a frame makes the next frame's first START chip follow immediately, with no idle gap.
- States:
  - IDLE -> SEND on accept.
  - SEND -> SEND on the final chip if a new word is accepted (counters reload).
  - SEND -> IDLE on the final chip with no accept.
- Counters:
  - chip_cnt runs 0..REP-1 and wraps to 0 at the end of each bit.
  - bit_cnt runs 0..DATA_W, where 0 is START; the shift register shifts left on wrap.
  - Widths are $clog2(REP) and $clog2(DATA_W+1), minimum 1.
- tx_last = (state==SEND) && bit_cnt==DATA_W && chip_cnt==REP-1.
- tx_hold=1 in SEND:
  - All state, counters and outputs hold their values and in_ready=0, including when tx_last is high.
  - The current chip is simply stretched.
- tx_hold in IDLE has no effect; a word can still be accepted.
- in_valid while not in_ready: ignored; no capture and no side effects.
- In IDLE: tx_bit=0 and tx_en=0.

Decomposition:
- Package rep_code_pkg holds:
  - DEF_DATA_W=8, DEF_REP=4, START_VAL=1'b1;
  - state enum {IDLE, SEND};
  - function frame_chips(dw, rep) = (1+dw)*rep, shared with the receiver and the bench.
- Sub-module rep_chip_counter generates chip_cnt/bit_cnt and wrap/last strobes, parameterised by REP and DATA_W, with hold input. The top level keeps the FSM, shift register and handshake.

Test Plan:
- Reset, then send 0xA5 (DATA_W=8, REP=4):
  - Required chip stream: 1111 1111 0000 1111 0000 0000 1111 0000 1111.
  - First chip is one cycle after the accept edge; tx_en high for exactly 36 cycles; tx_last only on cycle 36; in_ready=1 only in IDLE and on that last chip.
- in_valid held high with 0xFF then 0x00:
  - 72 consecutive tx_en cycles with no gap; second frame starts 1111 then 32 zeros; tx_last at cycles 36 and 72.
- tx_hold=1 for 3 cycles starting at chip 6 of 0x80 (data bit 7 = 1):
  - The chip-6 value is stretched by 3 cycles; frame lasts 39 cycles; in_ready stays 0 throughout.
- Assert tx_hold exactly on tx_last: no accept while held; tx_last stays high; the frame completes on the first cycle after hold drops.
- rst pulse at chip 20 of 0x3C:
  - Outputs go to 0 immediately, without waiting for a clock.
  - in_ready=1 the cycle after release; the next word 0x01 is sent correctly from START.
- in_valid with 0x55 while busy: not accepted and the current frame is unaltered. With REP=3, DATA_W=4, sending 0x1 must give 15 chips: 111 000 000 000 111.

Source files
------------

// File: rtl/rep_code_pkg.sv
// Shared definitions for the repetition-code transmit/receive pair: defaults,
// FSM state encoding and frame-length helper.
package rep_code_pkg;

  localparam int   DEF_DATA_W = 8;
  localparam int   DEF_REP    = 4;
  localparam logic START_VAL  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Chips in one frame: a start bit plus dw data bits, each repeated rep times.
  function automatic int frame_chips(input int dw, input int rep);
    return (1 + dw) * rep;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rep_chip_counter.sv
// Chip/bit position counter for one frame: chip_cnt 0..REP-1 inside a bit,
// bit_cnt 0..DATA_W across the frame (0 is the start bit).
module rep_chip_counter
  import rep_code_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int REP    = DEF_REP,
  localparam int CHIP_W = cnt_w(REP),
  localparam int BIT_W  = cnt_w(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_adv,
  output logic [CHIP_W-1:0] o_chip_cnt,
  output logic [BIT_W-1:0]  o_bit_cnt,
  output logic              o_last
);

  localparam logic [CHIP_W-1:0] CHIP_MAX = CHIP_W'(REP - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W);

  logic [CHIP_W-1:0] r_chip_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              w_chip_wrap;
  logic              w_bit_end;

  assign w_chip_wrap = (r_chip_cnt == CHIP_MAX);
  assign w_bit_end   = (r_bit_cnt == BIT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chip_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_load) begin
      r_chip_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_adv) begin
      if (w_chip_wrap) begin
        r_chip_cnt <= '0;
        r_bit_cnt  <= w_bit_end ? '0 : r_bit_cnt + 1'b1;
      end else begin
        r_chip_cnt <= r_chip_cnt + 1'b1;
      end
    end
  end

  assign o_chip_cnt = r_chip_cnt;
  assign o_bit_cnt  = r_bit_cnt;
  assign o_last     = w_chip_wrap && w_bit_end;

endmodule

// File: rtl/rep_code_tx.sv
// Repetition-code transmitter: accepts a word on valid/ready and emits a start
// bit then the data MSB first, every bit repeated REP times, one chip per clock.
module rep_code_tx
  import rep_code_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REP    = DEF_REP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              tx_hold,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              tx_last,
  output logic              busy
);

  localparam int                CHIP_W   = cnt_w(REP);
  localparam int                BIT_W    = cnt_w(DATA_W + 1);
  localparam logic [CHIP_W-1:0] CHIP_MAX = CHIP_W'(REP - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_shift;
  logic [CHIP_W-1:0]   w_chip_cnt;
  logic [BIT_W-1:0]    w_bit_cnt;
  logic                w_last_cnt;
  logic                w_ready;
  logic                w_accept;
  logic                w_adv;
  logic                w_send;

  assign w_send   = (r_state == SEND);
  assign w_adv    = w_send && !tx_hold;
  assign w_accept = in_valid && in_ready;

  rep_chip_counter #(
    .DATA_W (DATA_W),
    .REP    (REP)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept),
    .i_adv      (w_adv),
    .o_chip_cnt (w_chip_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_last     (w_last_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (in_valid) w_next_state = SEND;
      end
      SEND: begin
        if (w_last_cnt && !tx_hold) begin
          w_ready      = 1'b1;
          w_next_state = in_valid ? SEND : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Ready is masked by reset so no word is taken while the block is held in reset.
  assign in_ready = w_ready && !rst;

  // NOTE: the word register is reset even though it is don't-care in IDLE,
  // keeping its contents deterministic right after reset.
  // The start bit is not in the register, so the first shift happens at the
  // end of data bit 0 and the MSB is shown while bit_cnt == 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (w_accept) begin
      r_shift <= in_data;
    end else if (w_adv && (w_chip_cnt == CHIP_MAX) && (w_bit_cnt != '0)) begin
      r_shift <= r_shift << 1;
    end
  end

  assign tx_en   = w_send;
  assign busy    = w_send;
  assign tx_last = w_send && w_last_cnt;
  assign tx_bit  = w_send ? ((w_bit_cnt == '0) ? START_VAL : r_shift[DATA_W-1]) : 1'b0;

endmodule
